// File: rtl/nla_coeff_pkg.sv
// Shared constants and state type for the coefficient loader.
// Marker values are IEEE-754 single-precision NaN encodings.
package nla_coeff_pkg;

  localparam logic [31:0] START_MARKER = 32'h7F90_0000;
  localparam logic [31:0] QNAN_SUB     = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MARK,
    DONE
  } ld_state_e;

endpackage

// File: rtl/coeff_skid_buf.sv
// Two-entry FIFO holding coefficient table returns.
// Flush empties it in one cycle and overrides push/pop.
module coeff_skid_buf #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  input  logic          flush,
  output logic [1:0]    occ,
  output logic [DW-1:0] head
);

  logic [DW-1:0] mem [2];
  logic          wp;
  logic          rp;
  logic [1:0]    cnt;

  assign occ  = cnt;
  assign head = mem[rp];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/coeff_loader.sv
// Coefficient FIFO write-side sequencer: table -> FIFO, then start marker.
// Optional checksum_o port when COEFF_LOADER_CHECKSUM_EN is defined.
module coeff_loader
  import nla_coeff_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FUNC_BITS  = 3,
  parameter int MAX_COEFFS = 16,
  parameter int CIDX_BITS  = $clog2(MAX_COEFFS)
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          req_i,
  input  logic [FUNC_BITS-1:0]          func_i,
  input  logic [CIDX_BITS:0]            ncoeff_i,
  input  logic                          abort_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic                          tbl_rd_o,
  output logic [FUNC_BITS+CIDX_BITS-1:0] tbl_addr_o,
  input  logic [DATA_WIDTH-1:0]         tbl_data_i,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o
`ifdef COEFF_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]         checksum_o
`endif
);

  localparam int CW = CIDX_BITS + 1;
  localparam logic [CW-1:0] MAXN = CW'(MAX_COEFFS);
  localparam logic [DATA_WIDTH-1:0] MRK = DATA_WIDTH'(START_MARKER);
  localparam logic [DATA_WIDTH-1:0] SUB = DATA_WIDTH'(QNAN_SUB);

  ld_state_e             state_q;
  logic [FUNC_BITS-1:0]  func_q;
  logic [CW-1:0]         n_q;
  logic [CW-1:0]         rd_cnt_q;
  logic [CW-1:0]         pop_cnt_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;

  logic                  in_load;
  logic                  in_mark;
  logic [CW-1:0]         n_clamp;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head;
  logic                  pop;
  logic                  push;
  logic                  flush;
  logic                  collide;
  logic [DATA_WIDTH-1:0] push_data;
  logic [2:0]            outst;

  assign in_load = (state_q == LOAD);
  assign in_mark = (state_q == MARK);
  assign n_clamp = (ncoeff_i > MAXN) ? MAXN : ncoeff_i;

  assign pop   = in_load & (occ != 2'd0)
               & ~fifo_full_i & ~abort_i;
  assign push  = inflight_q & in_load & ~abort_i;
  assign flush = abort_i & (in_load | in_mark);

  assign collide   = push & (tbl_data_i == MRK);
  assign push_data = (tbl_data_i == MRK) ? SUB : tbl_data_i;

  // words buffered plus in flight, net of this cycle's pop
  assign outst = 3'(occ) + 3'(inflight_q) - 3'(pop);

  assign tbl_rd_o = in_load & ~abort_i
                  & (rd_cnt_q < n_q)
                  & (outst < 3'd2);
  assign tbl_addr_o = {func_q, rd_cnt_q[CIDX_BITS-1:0]};

  assign fifo_wr_en_o = pop
                      | (in_mark & ~fifo_full_i & ~abort_i);
  assign fifo_data_o  = (in_load && occ != 2'd0) ? head
                      : in_mark ? MRK
                      : data_q;

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);
  assign err_o  = err_q;

  coeff_skid_buf #(
    .DW(DATA_WIDTH)
  ) u_buf (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (push),
    .din    (push_data),
    .pop    (pop),
    .flush  (flush),
    .occ    (occ),
    .head   (head)
  );

`ifdef COEFF_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] cks_q;
  assign checksum_o = cks_q;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      func_q     <= '0;
      n_q        <= '0;
      rd_cnt_q   <= '0;
      pop_cnt_q  <= '0;
      inflight_q <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
`ifdef COEFF_LOADER_CHECKSUM_EN
      cks_q      <= '0;
`endif
    end else begin
      inflight_q <= tbl_rd_o;
      data_q     <= fifo_data_o;
      if (tbl_rd_o) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (pop) pop_cnt_q <= pop_cnt_q + 1'b1;
      if (collide) err_q <= 1'b1;
`ifdef COEFF_LOADER_CHECKSUM_EN
      if (pop) cks_q <= cks_q ^ head;
`endif
      unique case (state_q)
        IDLE: begin
          if (req_i) begin
            func_q    <= func_i;
            n_q       <= n_clamp;
            rd_cnt_q  <= '0;
            pop_cnt_q <= '0;
            err_q     <= 1'b0;
`ifdef COEFF_LOADER_CHECKSUM_EN
            cks_q     <= '0;
`endif
            state_q   <= (n_clamp == '0) ? MARK : LOAD;
          end
        end
        LOAD: begin
          if (abort_i) begin
            state_q <= IDLE;
          end else if (pop && (pop_cnt_q + 1'b1) == n_q) begin
            state_q <= MARK;
          end
        end
        MARK: begin
          if (abort_i) begin
            state_q <= IDLE;
          end else if (!fifo_full_i) begin
            state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_loader.sv
// Randomized self-checking bench for coeff_loader against a queue model.
// Define COEFF_LOADER_CHECKSUM_EN to also check checksum_o.
module tb_coeff_loader;

  localparam logic [31:0] MRK  = 32'h7F90_0000;
  localparam logic [31:0] QSUB = 32'h7FC0_0000;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b1;
  logic        req_i = 1'b0;
  logic [2:0]  func_i = '0;
  logic [4:0]  ncoeff_i = '0;
  logic        abort_i = 1'b0;
  logic        busy_o, done_o, err_o, tbl_rd_o;
  logic [6:0]  tbl_addr_o;
  logic [31:0] tbl_data_i = '0;
  logic        fifo_full_i = 1'b0;
  logic        fifo_wr_en_o;
  logic [31:0] fifo_data_o;
`ifdef COEFF_LOADER_CHECKSUM_EN
  logic [31:0] checksum_o;
`endif

  coeff_loader dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .req_i        (req_i),
    .func_i       (func_i),
    .ncoeff_i     (ncoeff_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .tbl_rd_o     (tbl_rd_o),
    .tbl_addr_o   (tbl_addr_o),
    .tbl_data_i   (tbl_data_i),
    .fifo_full_i  (fifo_full_i),
    .fifo_wr_en_o (fifo_wr_en_o),
    .fifo_data_o  (fifo_data_o)
`ifdef COEFF_LOADER_CHECKSUM_EN
    ,
    .checksum_o   (checksum_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int cnt = 0;
  int c0 = 0;
  int full_lo = 0;
  int full_hi = -1;
  bit rand_full = 0;
  bit chk_stable = 0;

  logic [31:0] tbl [128];
  logic [31:0] wq [$];
  int          cq [$];
  int          rdq_c [$];
  logic [6:0]  rdq_a [$];
  int          done_cnt, done_cyc, viol, stable_bad;
  logic        busy_at_done;
  logic [31:0] ck_at_done;
  logic        prev_full;
  logic [31:0] prev_data;

  logic [31:0] exp_q [$];
  bit          exp_err;
  logic [31:0] exp_ck;

  always @(posedge clk_i) cnt <= cnt + 1;

  // synchronous-read table model
  always @(posedge clk_i)
    if (tbl_rd_o) tbl_data_i <= tbl[tbl_addr_o];

  always @(posedge clk_i) begin
    int r;
    #1;
    r = cnt - c0 + 1;
    if (rand_full) fifo_full_i = ($urandom_range(0, 2) == 0);
    else fifo_full_i = (r >= full_lo && r <= full_hi);
  end

  always @(negedge clk_i) begin
    int r;
    if (rstn_i) begin
      r = cnt - c0 + 1;
      if (fifo_wr_en_o) begin
        wq.push_back(fifo_data_o);
        cq.push_back(r);
        if (fifo_full_i) viol++;
      end
      if (tbl_rd_o) begin
        rdq_c.push_back(r);
        rdq_a.push_back(tbl_addr_o);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = r;
        busy_at_done = busy_o;
`ifdef COEFF_LOADER_CHECKSUM_EN
        ck_at_done = checksum_o;
`else
        ck_at_done = '0;
`endif
      end
      if (chk_stable && prev_full && busy_o
          && fifo_data_o !== prev_data)
        stable_bad++;
      prev_full = fifo_full_i;
      prev_data = fifo_data_o;
    end
  end

  function automatic void build_exp(input int f, input int n);
    int nn;
    logic [31:0] w;
    nn = (n > 16) ? 16 : n;
    exp_q.delete();
    exp_err = 0;
    exp_ck = '0;
    for (int k = 0; k < nn; k++) begin
      w = tbl[f * 16 + k];
      if (w == MRK) begin
        w = QSUB;
        exp_err = 1;
      end
      exp_q.push_back(w);
      exp_ck ^= w;
    end
    exp_q.push_back(MRK);
  endfunction

  task automatic fill_tbl();
    for (int i = 0; i < 128; i++) begin
      tbl[i] = $urandom;
      if ($urandom_range(0, 9) == 0) tbl[i] = MRK;
    end
  endtask

  task automatic start(input int f, input int n);
    wq.delete();
    cq.delete();
    rdq_c.delete();
    rdq_a.delete();
    done_cnt = 0;
    viol = 0;
    stable_bad = 0;
    func_i = 3'(f);
    ncoeff_i = 5'(n);
    req_i = 1'b1;
    c0 = cnt + 1;
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++)
      @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #1 rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if ({busy_o, done_o, err_o, tbl_rd_o, fifo_wr_en_o,
         tbl_addr_o, fifo_data_o} !== '0) begin
      bad++;
      $display("FAIL reset_hold outs=%h required 0",
               {busy_o, done_o, err_o, tbl_rd_o,
                fifo_wr_en_o, tbl_addr_o, fifo_data_o});
    end
    rstn_i = 1'b1;
    @(negedge clk_i);
    total++;
    if ({busy_o, done_o, err_o, tbl_rd_o, fifo_wr_en_o,
         fifo_data_o} !== '0) begin
      bad++;
      $display("FAIL reset_release outs nonzero");
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 16; k++) tbl[32 + k] = 32'(k + 1);
    build_exp(2, 4);
    start(2, 4);
    wait_done(40);
    total++;
    if (wq.size() !== 5 || done_cnt !== 1) begin
      bad++;
      $display("FAIL basic_count writes=%0d done=%0d required 5/1",
               wq.size(), done_cnt);
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (wq[i] !== exp_q[i] || cq[i] !== 3 + i) begin
          bad++;
          $display("FAIL basic_w%0d got %h@%0d required %h@%0d",
                   i, wq[i], cq[i], exp_q[i], 3 + i);
        end
      end
      total++;
      if (done_cyc !== 8 || busy_at_done !== 1'b1) begin
        bad++;
        $display("FAIL basic_done cyc=%0d busy=%b required 8/1",
                 done_cyc, busy_at_done);
      end
    end
    total++;
    if (rdq_c.size() !== 4) begin
      bad++;
      $display("FAIL basic_reads n=%0d required 4", rdq_c.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (rdq_c[k] !== 1 + k || rdq_a[k] !== 7'(32 + k)) begin
          bad++;
          $display("FAIL basic_rd%0d got a=%h@%0d required %h@%0d",
                   k, rdq_a[k], rdq_c[k], 7'(32 + k), 1 + k);
        end
      end
    end
    total++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle busy=%b err=%b required 0/0",
               busy_o, err_o);
    end
  endtask

  task automatic test_backpressure();
    int f;
    f = $urandom_range(0, 7);
    build_exp(f, 8);
    full_lo = 4;
    full_hi = 7;
    chk_stable = 1;
    start(f, 8);
    wait_done(60);
    chk_stable = 0;
    full_lo = 0;
    full_hi = -1;
    total++;
    if (wq.size() !== 9 || done_cnt !== 1 || viol !== 0
        || stable_bad !== 0) begin
      bad++;
      $display("FAIL bp_summary writes=%0d done=%0d viol=%0d unstable=%0d required 9/1/0/0",
               wq.size(), done_cnt, viol, stable_bad);
    end else begin
      for (int i = 0; i < 9; i++) begin
        total++;
        if (wq[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL bp_w%0d got %h required %h",
                   i, wq[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_zero();
    start(4, 0);
    wait_done(20);
    total++;
    if (wq.size() !== 1 || rdq_c.size() !== 0 || done_cnt !== 1) begin
      bad++;
      $display("FAIL zero_count writes=%0d reads=%0d done=%0d required 1/0/1",
               wq.size(), rdq_c.size(), done_cnt);
    end else begin
      total++;
      if (wq[0] !== MRK || cq[0] !== 1 || done_cyc !== 2) begin
        bad++;
        $display("FAIL zero_mark got %h@%0d done@%0d required %h@1 done@2",
                 wq[0], cq[0], done_cyc, MRK);
      end
    end
  endtask

  task automatic test_clamp();
    build_exp(6, 20);
    start(6, 20);
    wait_done(80);
    total++;
    if (wq.size() !== 17 || done_cyc !== 20) begin
      bad++;
      $display("FAIL clamp writes=%0d done@%0d required 17 done@20",
               wq.size(), done_cyc);
    end else begin
      for (int i = 0; i < 17; i++) begin
        total++;
        if (wq[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL clamp_w%0d got %h required %h",
                   i, wq[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_collision();
    for (int k = 0; k < 16; k++) tbl[80 + k] = 32'(k) ^ 32'h1234_0000;
    tbl[82] = MRK;
    build_exp(5, 4);
    start(5, 4);
    wait_done(40);
    total++;
    if (wq.size() !== 5 || wq[2] !== QSUB || wq[4] !== MRK) begin
      bad++;
      $display("FAIL coll_words n=%0d w2=%h required 5 w2=%h",
               wq.size(), wq.size() > 2 ? wq[2] : 32'h0, QSUB);
    end
    repeat (3) @(posedge clk_i);
    #1;
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL coll_err_sticky got %b required 1", err_o);
    end
    start(5, 1);
    @(negedge clk_i);
    total++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL coll_err_clear err=%b busy=%b required 0/1",
               err_o, busy_o);
    end
    @(posedge clk_i);
    #1;
    wait_done(20);
  endtask

  task automatic test_abort();
    int f;
    f = 3;
    build_exp(f, 8);
    start(f, 8);
    repeat (4) @(posedge clk_i);
    #1;
    abort_i = 1'b1;
    @(posedge clk_i);
    #1;
    abort_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle busy=%b required 0", busy_o);
    end
    repeat (4) @(posedge clk_i);
    #1;
    total++;
    if (wq.size() !== 2 || done_cnt !== 0) begin
      bad++;
      $display("FAIL abort_writes n=%0d done=%0d required 2/0",
               wq.size(), done_cnt);
    end else begin
      total++;
      if (wq[0] !== exp_q[0] || wq[1] !== exp_q[1]) begin
        bad++;
        $display("FAIL abort_data got %h %h required %h %h",
                 wq[0], wq[1], exp_q[0], exp_q[1]);
      end
    end
    build_exp(f, 2);
    start(f, 2);
    wait_done(30);
    total++;
    if (done_cnt !== 1 || wq.size() !== 3 || wq[0] !== exp_q[0]
        || wq[1] !== exp_q[1] || wq[2] !== MRK) begin
      bad++;
      $display("FAIL abort_reload done=%0d n=%0d required 1/3",
               done_cnt, wq.size());
    end
  endtask

  task automatic test_async_reset();
    start(1, 8);
    repeat (3) @(posedge clk_i);
    #2;
    rstn_i = 1'b0;
    #1;
    total++;
    if ({busy_o, done_o, err_o, tbl_rd_o, fifo_wr_en_o,
         tbl_addr_o, fifo_data_o} !== '0) begin
      bad++;
      $display("FAIL async_reset outs=%h required 0",
               {busy_o, done_o, err_o, tbl_rd_o,
                fifo_wr_en_o, tbl_addr_o, fifo_data_o});
    end
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_random();
    int f, n;
    for (int it = 0; it < 8; it++) begin
      fill_tbl();
      f = $urandom_range(0, 7);
      n = $urandom_range(0, 20);
      build_exp(f, n);
      rand_full = 1;
      start(f, n);
      wait_done(300);
      rand_full = 0;
      total++;
      if (done_cnt !== 1 || viol !== 0
          || wq.size() !== exp_q.size() || err_o !== exp_err
          || ck_at_done !== exp_ck && `ifdef COEFF_LOADER_CHECKSUM_EN 1 `else 0 `endif) begin
        bad++;
        $display("FAIL rand%0d done=%0d viol=%0d n=%0d/%0d err=%b/%b ck=%h/%h",
                 it, done_cnt, viol, wq.size(), exp_q.size(),
                 err_o, exp_err, ck_at_done, exp_ck);
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          total++;
          if (wq[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL rand%0d_w%0d got %h required %h",
                     it, i, wq[i], exp_q[i]);
          end
        end
      end
    end
  endtask

`ifdef COEFF_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    tbl[112] = 32'hA5A5_A5A5;
    tbl[113] = 32'h0F0F_0F0F;
    start(7, 2);
    wait_done(30);
    total++;
    if (done_cnt !== 1 || ck_at_done !== 32'hAAAA_AAAA) begin
      bad++;
      $display("FAIL checksum got %h required AAAAAAAA", ck_at_done);
    end
  endtask
`endif

  initial begin
    fill_tbl();
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_clamp();
    test_collision();
    test_abort();
    test_async_reset();
    test_random();
`ifdef COEFF_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
